// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_ctrl_pkg;

  // Fetch controller states (2-bit encoding).
  typedef enum logic [1:0] {
    IF_DISABLED = 2'b00,
    IF_FETCH    = 2'b01,
    IF_OUT      = 2'b10,
    IF_KILL     = 2'b11
  } if_state_t;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

endpackage

// File: rtl/if_redirect_arb.sv
// Redirect arbiter: flush beats branch, target forced to word alignment.
module if_redirect_arb #(
  parameter int ADDR_W = 32
) (
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_target
);

  // Priority select of the redirect source and alignment of its target.
  always_comb begin
    redir_valid  = flush_i | branch_i;
    redir_target = flush_i ? flush_pc_i : branch_pc_i;
    redir_target[1:0] = 2'b00;
  end

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time,
// presents the returned instruction to ID and applies flush/branch redirects.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IF_DISABLED | memory disabled; leaves on the first edge after reset
// IF_FETCH    | request outstanding at pc_o, no instruction held
// IF_OUT      | instruction held for ID; fetches the next one when not stalled
// IF_KILL     | outstanding request must be discarded; redir_pc is the target
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  output logic              ce_o,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              ack_i,
  input  logic [INST_W-1:0] inst_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);

  if_state_t         state;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;

  if_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .branch_i     (branch_i),
    .branch_pc_i  (branch_pc_i),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
  );

  assign addr_o = pc_o;

  // Request is held high while a fetch is outstanding; in OUT it only goes
  // out when the held instruction is being consumed and no redirect is seen.
  always_comb begin
    req_o = 1'b0;
    case (state)
      IF_FETCH: req_o = 1'b1;
      IF_OUT:   req_o = ~stall_i & ~redir_valid;
      IF_KILL:  req_o = 1'b1;
      default:  req_o = 1'b0;
    endcase
  end

  // Fetch FSM with PC, redirect target and ID-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state        <= IF_DISABLED;
      ce_o         <= CHIP_DISABLE;
      pc_o         <= RESET_PC;
      redir_pc     <= '0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state)
        IF_DISABLED: begin
          state <= IF_FETCH;
          ce_o  <= CHIP_ENABLE;
          // branch is meaningless before the first fetch; only flush counts
          if (flush_i) pc_o <= redir_target;
        end
        IF_FETCH: begin
          if (ack_i) begin
            if (redir_valid) begin
              pc_o <= redir_target;
            end else begin
              inst_o       <= inst_rdata_i;
              inst_pc_o    <= pc_o;
              inst_valid_o <= 1'b1;
              pc_o         <= pc_o + ADDR_W'(4);
              state        <= IF_OUT;
            end
          end else if (redir_valid) begin
            // keep addr_o stable until the memory answers
            redir_pc <= redir_target;
            state    <= IF_KILL;
          end
        end
        IF_OUT: begin
          if (redir_valid) begin
            inst_valid_o <= 1'b0;
            pc_o         <= redir_target;
            state        <= IF_FETCH;
          end else if (!stall_i) begin
            if (ack_i) begin
              inst_o    <= inst_rdata_i;
              inst_pc_o <= pc_o;
              pc_o      <= pc_o + ADDR_W'(4);
            end else begin
              inst_valid_o <= 1'b0;
              state        <= IF_FETCH;
            end
          end
        end
        IF_KILL: begin
          if (ack_i) begin
            pc_o  <= redir_valid ? redir_target : redir_pc;
            state <= IF_FETCH;
          end else if (redir_valid) begin
            redir_pc <= redir_target;
          end
        end
        default: state <= IF_DISABLED;
      endcase
    end
  end

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: directed scenarios then random traffic, all compared
// against a transaction-level model of the fetch stream.
module tb_if_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        ack_en = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic [31:0] branch_pc_i = '0;
  logic        ce_o, req_o, ack_i, inst_valid_o;
  logic [31:0] addr_o, inst_rdata_i, pc_o, inst_o, inst_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state: what the next delivered instruction's address must be,
  // whether the outstanding request is doomed, and what ID should see
  logic        m_ce, m_valid, m_doomed;
  logic [31:0] m_next, m_doom_addr, m_inst, m_inst_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // zero-latency memory whenever ack_en is set
  assign ack_i        = req_o & ack_en;
  assign inst_rdata_i = memval(addr_o);

  if_ctrl #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .branch_i     (branch_i),
    .branch_pc_i  (branch_pc_i),
    .ce_o         (ce_o),
    .req_o        (req_o),
    .addr_o       (addr_o),
    .ack_i        (ack_i),
    .inst_rdata_i (inst_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ce      = 1'b0;
    m_valid   = 1'b0;
    m_doomed  = 1'b0;
    m_next    = 32'h0;
    m_doom_addr = 32'h0;
    m_inst    = 32'h0;
    m_inst_pc = 32'h0;
  endtask

  // Called at a negedge: drive one cycle of inputs, compare, advance model.
  task automatic step(input logic s, input logic f, input logic [31:0] fp,
                      input logic b, input logic [31:0] bp, input logic a);
    logic        redir, mreq, acc;
    logic [31:0] tgt, exp_pc;
    stall_i = s; flush_i = f; flush_pc_i = fp;
    branch_i = b; branch_pc_i = bp; ack_en = a;
    #1;
    redir  = m_ce && (f || b);
    tgt    = f ? fp : bp;
    tgt[1:0] = 2'b00;
    mreq   = m_ce && !(m_valid && (s || redir));
    exp_pc = m_doomed ? m_doom_addr : m_next;
    chk("ce", {31'b0, ce_o}, {31'b0, m_ce});
    chk("req", {31'b0, req_o}, {31'b0, mreq});
    chk("valid", {31'b0, inst_valid_o}, {31'b0, m_valid});
    chk("inst", inst_o, m_inst);
    chk("inst_pc", inst_pc_o, m_inst_pc);
    chk("pc", pc_o, exp_pc);
    if (mreq) chk("addr", addr_o, exp_pc);
    if (!m_ce) begin
      m_ce = 1'b1;
      if (f) begin
        m_next = fp;
        m_next[1:0] = 2'b00;
      end
    end else begin
      acc = mreq && a && !redir && !m_doomed;
      if (mreq && a) begin
        m_doomed = 1'b0;
      end else if (mreq && redir && !m_doomed) begin
        m_doomed    = 1'b1;
        m_doom_addr = m_next;
      end
      if (acc) begin
        m_inst    = memval(m_next);
        m_inst_pc = m_next;
        m_valid   = 1'b1;
        m_next    = m_next + 32'd4;
      end else if (redir) begin
        m_valid = 1'b0;
        m_next  = tgt;
      end else begin
        m_valid = m_valid && s;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ce", {31'b0, ce_o}, 32'h0);
    chk("rst_req", {31'b0, req_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    rst = 1'b0;

    // sequential fetch with ack tied high
    repeat (4) step(0, 0, 0, 0, 0, 1);
    chk("seq_pc8", inst_pc_o, 32'h8);

    // stall for 3 cycles in OUT, then resume
    repeat (3) step(1, 0, 0, 0, 0, 1);
    chk("stall_hold", inst_pc_o, 32'h8);
    step(0, 0, 0, 0, 0, 1);
    chk("stall_resume", inst_pc_o, 32'hC);

    // branch in OUT to an unaligned target
    step(0, 0, 0, 1, 32'h103, 1);
    chk("br_addr", addr_o, 32'h100);

    // branch while waiting on a slow memory
    step(0, 0, 0, 1, 32'h200, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    chk("kill_addr", addr_o, 32'h100);
    step(0, 0, 0, 0, 0, 1);
    chk("kill_tgt", addr_o, 32'h200);
    step(0, 0, 0, 0, 0, 1);

    // flush+branch together, then a second flush while killing
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h80, 1, 32'h40, 0);
    step(0, 1, 32'h180, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("flush_tgt", addr_o, 32'h180);

    // wrap of the PC at the top of the address space
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_addr", addr_o, 32'h0);
    chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);

    // async reset while in KILL
    step(0, 1, 32'h300, 0, 0, 0);
    step(0, 1, 32'h304, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ce", {31'b0, ce_o}, 32'h0);
    chk("arst_req", {31'b0, req_o}, 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("arst_inst", inst_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 30),
           ($urandom_range(99) < 5), $urandom,
           ($urandom_range(99) < 8), $urandom,
           ($urandom_range(99) < 60));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_ctrl.md
Name: if_ctrl

Overview:
Instruction-fetch controller that sequences the PC and shares the instruction-memory port with the pipeline. It issues one fetch request at a time and captures the returned instruction for the ID stage. It holds the instruction under pipeline stall and applies flush and branch redirects. It sits between the pipeline control/branch logic and the instruction memory, and it owns the PC register and the chip-enable for instruction memory.

Parameters:
ADDR_W, 32, width of instruction address bus (InstAddrBus)
INST_W, 32, width of instruction word (InstBus)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high (RstEnable = 1'b1)
stall_i  in  1  downstream (IF/ID) stall; instruction not consumed this cycle
flush_i  in  1  exception/flush redirect request
flush_pc_i  in  ADDR_W  flush target
branch_i  in  1  taken-branch redirect request
branch_pc_i  in  ADDR_W  branch target
ce_o  out  1  instruction memory chip enable (ChipEnable/ChipDisable)
req_o  out  1  fetch request valid
addr_o  out  ADDR_W  fetch address; equals pc_o
ack_i  in  1  memory accepted request and inst_rdata_i valid (may be same cycle as req_o)
inst_rdata_i  in  INST_W  fetched instruction
pc_o  out  ADDR_W  current fetch PC
inst_o  out  INST_W  instruction to ID
inst_pc_o  out  ADDR_W  address of inst_o
inst_valid_o  out  1  inst_o valid

Behaviour:
- Reset, async, while rst=1: state=DISABLED. pc_o=RESET_PC, ce_o=0, req_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, redir_pc=0.
- States: DISABLED, FETCH, OUT, KILL. ce_o=1 in every state except DISABLED.
- DISABLED: on the first clk edge after rst drops, go to FETCH. Fetch therefore starts 1 cycle after reset release.
  - flush_i in DISABLED: pc_o<=flush_pc_i.
  - branch_i in DISABLED: ignored.
- FETCH: req_o=1, addr_o=pc_o.
  - ack_i and no redirect: inst_o<=inst_rdata_i, inst_pc_o<=pc_o, inst_valid_o<=1, pc_o<=pc_o+4, go to OUT.
  - ack_i with redirect: discard data, pc_o<=target, stay in FETCH.
  - no ack_i with redirect: redir_pc<=target, go to KILL. addr_o stays stable until ack.
- OUT: inst_valid_o=1.
  - stall_i=1: hold inst_o, inst_pc_o and pc_o; req_o=0.
  - stall_i=0: instruction consumed; req_o=1 at pc_o (back-to-back fetch).
    - ack_i: load the new inst and pc_o+4, stay in OUT.
    - no ack_i: inst_valid_o<=0, go to FETCH.
  - redirect in OUT (overrides stall): req_o forced 0, inst_valid_o<=0, pc_o<=target, go to FETCH.
- KILL: req_o=1, addr_o=old pc_o, inst_valid_o=0.
  - Further redirects overwrite redir_pc (same priority rule).
  - On ack_i: discard data, pc_o<=redir_pc (or the new target if a redirect arrives in the same cycle), go to FETCH.
- Redirect priority: flush_i > branch_i > sequential. Target low 2 bits forced to 2'b00.
- Arithmetic: pc_o+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0).
- Invariants:
  - req_o never drops while waiting for ack_i.
  - Exactly one outstanding request.
  - Data acked in KILL, or acked in a redirect cycle, never reaches inst_o.
- Reset mid-request: all state cleared immediately, in-flight ack ignored. Memory must tolerate request abandonment on reset.
- Throughput: 1 inst/cycle with a zero-wait (combinational) ack; N-wait memory gives 1 inst per N+1 cycles.

Decomposition:
- defines.v: InstAddrBus, InstBus, ChipEnable/ChipDisable, RstEnable, ZeroWord, plus new state macros IfDisabled/IfFetch/IfOut/IfKill (2-bit).
- Sub-module if_redirect_arb: combinational flush>branch priority select producing redir_valid and the aligned redir_target. The FSM, PC and output registers stay in if_ctrl.

Test Plan:
- Reset release, ack_i tied 1, no stall -> ce_o rises 1 cycle after release; inst_pc_o sequence 0x0, 0x4, 0x8, one per cycle.
- Stall in OUT: stall_i=1 for 3 cycles at inst_pc_o=0x8 -> inst_o/inst_pc_o held, req_o=0; resumes at 0xC after release.
- Branch in OUT: branch_i, branch_pc_i=0x103 -> inst_valid_o=0 next cycle; next fetch addr_o=0x100.
- Branch while waiting (ack delayed 3 cycles): branch_pc_i=0x200 -> addr_o stays at old PC until ack, old data discarded, next addr_o=0x200.
- Flush and branch in the same cycle (flush_pc_i=0x80, branch_pc_i=0x40), then a second flush during KILL (0x180) -> final fetch at 0x180.
- Wrap and async reset: pc_o=0xFFFF_FFFC acked -> next addr_o=0x0. Assert rst mid-KILL -> outputs cleared without a clock edge.
